// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and sizing constants for the L2 bank port arbiter.
// Defaults describe a 4-requester bank with 16 MSHRs.
package l2_port_arbiter_pkg;

    localparam int unsigned L2_PORTS        = 4;
    localparam int unsigned ADDR_BITS       = 34;
    localparam int unsigned L2_DATA_W       = 32;
    localparam int unsigned LOG_N_MSHR      = 4;
    localparam int unsigned L2_MAX_OUTSTAND = 1 << LOG_N_MSHR;

    // Port id width, kept at least one bit so a single-port build still elaborates.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PORT_ID_W = id_width(L2_PORTS);

    typedef logic [PORT_ID_W-1:0] l2_port_id_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 wr;
        logic [L2_DATA_W-1:0] wdata;
        l2_port_id_t          port;
    } l2_req_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Requester, bank-request and bank-response bundle around one L2 bank arbiter.
// The slave modport is the arbiter's view; master is the surrounding tile.
interface l2_port_arbiter_if
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS = L2_PORTS,
    parameter int unsigned ADDR_W  = ADDR_BITS,
    parameter int unsigned DATA_W  = L2_DATA_W
) ();
    localparam int unsigned ID_W = id_width(N_PORTS);

    logic [N_PORTS-1:0]             req_valid;
    logic [N_PORTS-1:0]             req_ready;
    logic [N_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [N_PORTS-1:0]             req_wr;
    logic [N_PORTS-1:0][DATA_W-1:0] req_wdata;

    logic                           l2_valid;
    logic                           l2_ready;
    logic [ADDR_W-1:0]              l2_addr;
    logic                           l2_wr;
    logic [DATA_W-1:0]              l2_wdata;
    logic [ID_W-1:0]                l2_port;

    logic                           l2_resp_valid;
    logic [ID_W-1:0]                l2_resp_port;
    logic [DATA_W-1:0]              l2_resp_data;
    logic [N_PORTS-1:0]             resp_valid;
    logic [DATA_W-1:0]              resp_data;

    modport slave (
        input  req_valid, req_addr, req_wr, req_wdata, l2_ready,
               l2_resp_valid, l2_resp_port, l2_resp_data,
        output req_ready, l2_valid, l2_addr, l2_wr, l2_wdata, l2_port,
               resp_valid, resp_data
    );

    modport master (
        output req_valid, req_addr, req_wr, req_wdata, l2_ready,
               l2_resp_valid, l2_resp_port, l2_resp_data,
        input  req_ready, l2_valid, l2_addr, l2_wr, l2_wdata, l2_port,
               resp_valid, resp_data
    );

endinterface

// File: rtl/l2_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module l2_port_arbiter_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ID_W'((32'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 bank among N_PORTS requesters, with a registered
// request stage, MSHR-sized credit limit and registered response demux.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS      = L2_PORTS,
    parameter int unsigned ADDR_W       = ADDR_BITS,
    parameter int unsigned DATA_W       = L2_DATA_W,
    parameter int unsigned MAX_OUTSTAND = L2_MAX_OUTSTAND,
    localparam int unsigned CNT_W       = $clog2(MAX_OUTSTAND + 1),
    localparam int unsigned ID_W        = id_width(N_PORTS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    l2_port_arbiter_if.slave     bus,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 err_underflow
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               l2_valid_q, l2_valid_d;
    logic [ADDR_W-1:0]  l2_addr_q, l2_addr_d;
    logic               l2_wr_q, l2_wr_d;
    logic [DATA_W-1:0]  l2_wdata_q, l2_wdata_d;
    logic [ID_W-1:0]    l2_port_q, l2_port_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [N_PORTS-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;

    logic [N_PORTS-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               pick_valid;
    logic               resp;
    logic               resp_port_ok;
    logic               out_free;
    logic               credit_ok;
    logic               accept;

    l2_port_arbiter_rr_pick #(
        .N    (N_PORTS),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .valid   (pick_valid)
    );

    assign resp         = bus.l2_resp_valid;
    assign resp_port_ok = 32'(bus.l2_resp_port) < N_PORTS;
    assign out_free     = !l2_valid_q || bus.l2_ready;
    // A request held in the output register was counted at accept, so cnt_q alone is the load.
    assign credit_ok    = (cnt_q < CNT_W'(MAX_OUTSTAND)) || resp;
    assign accept       = rstn && out_free && credit_ok && pick_valid;
    assign bus.req_ready = accept ? gnt : '0;

    always_comb begin
        ptr_d        = ptr_q;
        l2_valid_d   = l2_valid_q;
        l2_addr_d    = l2_addr_q;
        l2_wr_d      = l2_wr_q;
        l2_wdata_d   = l2_wdata_q;
        l2_port_d    = l2_port_q;
        cnt_d        = cnt_q;
        err_d        = err_q | (resp && (cnt_q == '0 || !resp_port_ok));
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;

        if (accept) begin
            l2_valid_d = 1'b1;
            l2_addr_d  = bus.req_addr[gnt_idx];
            l2_wr_d    = bus.req_wr[gnt_idx];
            l2_wdata_d = bus.req_wdata[gnt_idx];
            l2_port_d  = gnt_idx;
            ptr_d      = (32'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        end else if (bus.l2_ready) begin
            l2_valid_d = 1'b0;
        end

        if (accept && !resp) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && resp && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (resp) begin
            resp_data_d = bus.l2_resp_data;
            if (resp_port_ok) begin
                resp_valid_d[bus.l2_resp_port] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q        <= '0;
            l2_valid_q   <= 1'b0;
            l2_addr_q    <= '0;
            l2_wr_q      <= 1'b0;
            l2_wdata_q   <= '0;
            l2_port_q    <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            l2_valid_q   <= l2_valid_d;
            l2_addr_q    <= l2_addr_d;
            l2_wr_q      <= l2_wr_d;
            l2_wdata_q   <= l2_wdata_d;
            l2_port_q    <= l2_port_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.l2_valid   = l2_valid_q;
    assign bus.l2_addr    = l2_addr_q;
    assign bus.l2_wr      = l2_wr_q;
    assign bus.l2_wdata   = l2_wdata_q;
    assign bus.l2_port    = l2_port_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign outstanding    = cnt_q;
    assign err_underflow  = err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_l2_port_arbiter;
    import l2_port_arbiter_pkg::*;

    localparam int unsigned N     = L2_PORTS;
    localparam int unsigned MAX   = L2_MAX_OUTSTAND;
    localparam int unsigned CNT_W = $clog2(MAX + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [CNT_W-1:0] outstanding;
    logic             err_underflow;

    l2_port_arbiter_if bus ();

    l2_port_arbiter dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester payloads and reference model state
    l2_req_t          cur [N];
    bit               m_l2v;
    l2_req_t          m_out;
    int               m_ptr;
    int               m_cnt;
    bit               m_err;
    logic [N-1:0]     m_respv;
    logic [31:0]      m_rdata;
    int               m_gnt;
    int               dut_gnt;
    int               dut_acc;
    int               bank_q[$];

    task automatic new_req(input int p);
        cur[p].addr  = ADDR_BITS'({$urandom, $urandom});
        cur[p].wr    = 1'($urandom_range(0, 1));
        cur[p].wdata = $urandom;
        cur[p].port  = l2_port_id_t'(p);
    endtask

    task automatic model_reset();
        m_l2v   = 1'b0;
        m_out   = '0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_respv = '0;
        m_rdata = '0;
        bank_q.delete();
    endtask

    // One clock: drive, check the combinational accept, advance model, check registered outputs.
    task automatic step();
        logic [N-1:0] exp_rdy;
        bit           resp;
        int           rport;
        for (int p = 0; p < N; p++) begin
            bus.req_addr[p]  = cur[p].addr;
            bus.req_wr[p]    = cur[p].wr;
            bus.req_wdata[p] = cur[p].wdata;
        end
        #2;
        m_gnt = -1;
        if (rstn && (!m_l2v || bus.l2_ready) && (m_cnt < MAX || bus.l2_resp_valid)) begin
            for (int k = 0; k < N; k++) begin
                if (m_gnt < 0 && bus.req_valid[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
            end
        end
        exp_rdy = (m_gnt >= 0) ? (N'(1) << m_gnt) : '0;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        dut_gnt = -1;
        for (int k = 0; k < N; k++) if (bus.req_ready[k]) dut_gnt = k;
        if (bus.req_ready != '0) dut_acc++;

        resp  = bus.l2_resp_valid;
        rport = int'(bus.l2_resp_port);
        if (!rstn) begin
            model_reset();
        end else begin
            if (m_l2v && bus.l2_ready) bank_q.push_back(int'(m_out.port));
            if (m_gnt >= 0) begin
                m_l2v = 1'b1;
                m_out = cur[m_gnt];
                m_ptr = (m_gnt + 1) % N;
            end else if (bus.l2_ready) begin
                m_l2v = 1'b0;
            end
            if (resp && (m_cnt == 0 || rport >= N)) m_err = 1'b1;
            if (m_gnt >= 0 && !resp) m_cnt++;
            else if (m_gnt < 0 && resp && m_cnt > 0) m_cnt--;
            m_respv = (resp && rport < N) ? (N'(1) << rport) : '0;
            if (resp) m_rdata = bus.l2_resp_data;
        end

        @(posedge clk);
        #1;
        check("l2_valid", 64'(bus.l2_valid), 64'(m_l2v));
        check("outstanding", 64'(outstanding), 64'(m_cnt));
        check("err_underflow", 64'(err_underflow), 64'(m_err));
        check("resp_valid", 64'(bus.resp_valid), 64'(m_respv));
        if (m_l2v) begin
            check("l2_addr", 64'(bus.l2_addr), 64'(m_out.addr));
            check("l2_wr", 64'(bus.l2_wr), 64'(m_out.wr));
            check("l2_wdata", 64'(bus.l2_wdata), 64'(m_out.wdata));
            check("l2_port", 64'(bus.l2_port), 64'(m_out.port));
        end
        if (m_respv != '0) check("resp_data", 64'(bus.resp_data), 64'(m_rdata));
    endtask

    task automatic refresh_granted();
        if (m_gnt >= 0) new_req(m_gnt);
    endtask

    initial begin
        int guard;
        bus.req_valid     = '0;
        bus.l2_ready      = 1'b0;
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_port  = '0;
        bus.l2_resp_data  = '0;
        dut_acc           = 0;
        for (int p = 0; p < N; p++) new_req(p);
        model_reset();

        // Reset held with every requester asserting
        rstn          = 1'b0;
        bus.req_valid = '1;
        bus.l2_ready  = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step();
        check("rst_l2_addr", 64'(bus.l2_addr), 64'd0);
        check("rst_l2_port", 64'(bus.l2_port), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data), 64'd0);

        // Round-robin order with everyone valid
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_order", 64'(dut_gnt), 64'(i % N));
            refresh_granted();
        end

        // Backpressure right after port 2 is granted
        guard = 0;
        do begin
            step();
            refresh_granted();
            guard++;
        end while (dut_gnt != 2 && guard < 8);
        check("bp_reach_port2", 64'(dut_gnt), 64'd2);
        bus.l2_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_port", 64'(bus.l2_port), 64'd2);
            check("bp_no_grant", 64'(dut_gnt), -64'sd1);
        end
        bus.l2_ready = 1'b1;
        step();
        check("bp_drain_grant", 64'(dut_gnt), 64'd3);
        refresh_granted();

        // Credit limit
        rstn = 1'b0;
        step();
        rstn    = 1'b1;
        dut_acc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            refresh_granted();
        end
        check("credit_accepts", 64'(dut_acc), 64'(MAX));
        check("credit_full", 64'(outstanding), 64'(MAX));
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_port  = '0;
        bus.l2_resp_data  = $urandom;
        step();
        refresh_granted();
        bus.l2_resp_valid = 1'b0;
        step();
        check("credit_one_more", 64'(dut_acc), 64'(MAX + 1));
        check("credit_still_full", 64'(outstanding), 64'(MAX));

        // Response routing
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_port  = l2_port_id_t'(3);
        bus.l2_resp_data  = 32'hDEADBEEF;
        step();
        refresh_granted();
        bus.l2_resp_valid = 1'b0;
        check("route_valid", 64'(bus.resp_valid), 64'(4'b1000));
        check("route_data", 64'(bus.resp_data), 64'h0000_0000_DEAD_BEEF);

        // Underflow
        rstn          = 1'b0;
        bus.req_valid = '0;
        step();
        rstn              = 1'b1;
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_port  = l2_port_id_t'(1);
        bus.l2_resp_data  = $urandom;
        step();
        bus.l2_resp_valid = 1'b0;
        check("uf_err", 64'(err_underflow), 64'd1);
        check("uf_cnt", 64'(outstanding), 64'd0);
        repeat (3) step();
        check("uf_sticky", 64'(err_underflow), 64'd1);

        // Random traffic with a mid-run reset
        rstn = 1'b0;
        step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rstn = (cyc != 1500);
            for (int p = 0; p < N; p++) begin
                if (!bus.req_valid[p] && $urandom_range(0, 2) == 0) begin
                    new_req(p);
                    bus.req_valid[p] = 1'b1;
                end
            end
            bus.l2_ready = ($urandom_range(0, 3) != 0);
            if (bank_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.l2_resp_valid = 1'b1;
                bus.l2_resp_port  = l2_port_id_t'(bank_q.pop_front());
                bus.l2_resp_data  = $urandom;
            end else begin
                bus.l2_resp_valid = 1'b0;
            end
            step();
            if (m_gnt >= 0) begin
                if ($urandom_range(0, 1) == 0) bus.req_valid[m_gnt] = 1'b0;
                else new_req(m_gnt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
